// File: rtl/uart_rx_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_rx_responder_if
// Purpose   : Per-core read-only address/data channel bundle between the
//             requesting cores and the UART RX responder.
// Signals   : s_arvalid/s_araddr/s_rready driven by the cores (master),
//             s_arready/s_rvalid/s_rdata/s_rresp driven by the responder
//             (slave). Core i owns bit i of the 1-bit vectors, bits
//             [32i+31:32i] of the 32-bit vectors and [2i+1:2i] of s_rresp.
// Revision  : 1.0 - initial release
// ============================================================================
interface uart_rx_responder_if #(
  parameter int NUM_CPUS = 2
) ();

  logic [NUM_CPUS-1:0]    s_arvalid;
  logic [32*NUM_CPUS-1:0] s_araddr;
  logic [NUM_CPUS-1:0]    s_arready;
  logic [NUM_CPUS-1:0]    s_rvalid;
  logic [32*NUM_CPUS-1:0] s_rdata;
  logic [2*NUM_CPUS-1:0]  s_rresp;
  logic [NUM_CPUS-1:0]    s_rready;

  modport master (
    output s_arvalid, s_araddr, s_rready,
    input  s_arready, s_rvalid, s_rdata, s_rresp
  );

  modport slave (
    input  s_arvalid, s_araddr, s_rready,
    output s_arready, s_rvalid, s_rdata, s_rresp
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_responder
// Purpose  : Buffers bytes from a UART receiver in a FIFO and serves them to
//            several cores over per-core read channels, arbitrated
//            round-robin. BASE_ADDR reads pop a byte, BASE_ADDR+4 reads the
//            status word (count, sticky overflow, non-empty) and clears the
//            overflow flag; anything else answers SLVERR.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            i_Rx_DV    - one-cycle valid strobe for i_Rx_Byte
//            i_Rx_Byte  - received byte
//            rx_irq     - (UART_RX_IRQ_EN only) high while data or overflow
//            bus        - uart_rx_responder_if.slave read channels
// Options  : define UART_RX_IRQ_EN to add the rx_irq output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_responder #(
  parameter int          NUM_CPUS   = 2,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h6000_0100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
`ifdef UART_RX_IRQ_EN
  output logic       rx_irq,
`endif
  uart_rx_responder_if.slave bus
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_GNT_W = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;

  localparam logic [31:0]        c_STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [1:0]         c_RESP_OKAY   = 2'b00;
  localparam logic [1:0]         c_RESP_SLVERR = 2'b10;
  localparam logic [c_CNT_W-1:0] c_FULL_COUNT  = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_GNT_W-1:0] c_LAST_CPU    = c_GNT_W'(NUM_CPUS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_GNT_W-1:0]   r_grant;
  logic [c_GNT_W-1:0]   w_next_grant;
  logic [c_GNT_W-1:0]   r_rr_ptr;
  logic [c_GNT_W-1:0]   w_rr_pick;
  logic [c_GNT_W-1:0]   w_idx;
  int                   w_sum;
  logic                 w_found;

  logic                 w_arvalid_g;
  logic                 w_rready_g;
  logic [31:0]          w_addr;

  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_CNT_W-1:0]   w_count_nxt;
  logic [7:0]           w_count8;
  logic                 r_ovf;
  logic                 w_ovf_nxt;

  logic                 w_hs;
  logic                 w_is_data;
  logic                 w_is_stat;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_ovf_clr;

  logic [31:0]          r_rdata;
  logic [1:0]           r_rresp;
  logic [31:0]          w_resp_data;
  logic [1:0]           w_resp_code;

  // Signals of the currently granted core.
  always_comb begin
    w_arvalid_g = 1'b0;
    w_rready_g  = 1'b0;
    w_addr      = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (r_grant == c_GNT_W'(i)) begin
        w_arvalid_g = bus.s_arvalid[i];
        w_rready_g  = bus.s_rready[i];
        w_addr      = bus.s_araddr[32*i +: 32];
      end
    end
  end

  // Round-robin pick: first requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_rr_pick = r_rr_ptr;
    w_found   = 1'b0;
    w_sum     = 0;
    w_idx     = '0;
    for (int k = 0; k < NUM_CPUS; k++) begin
      w_sum = int'(r_rr_ptr) + k;
      if (w_sum >= NUM_CPUS) begin
        w_sum = w_sum - NUM_CPUS;
      end
      w_idx = c_GNT_W'(w_sum);
      if (!w_found && bus.s_arvalid[w_idx]) begin
        w_found   = 1'b1;
        w_rr_pick = w_idx;
      end
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_FULL_COUNT);
  assign w_hs      = (r_state == S_ADDR) && w_arvalid_g;
  assign w_is_data = (w_addr == BASE_ADDR);
  assign w_is_stat = (w_addr == c_STATUS_ADDR);
  assign w_pop     = w_hs && w_is_data && !w_empty;
  // A full FIFO still accepts a byte when a pop frees a slot this cycle.
  assign w_push    = i_Rx_DV && (!w_full || w_pop);
  assign w_drop    = i_Rx_DV && w_full && !w_pop;
  assign w_ovf_clr = w_hs && w_is_stat;
  // Overflow in the same cycle as a status read keeps the flag set.
  assign w_ovf_nxt = w_drop | (r_ovf & ~w_ovf_clr);
  assign w_count8  = 8'(r_count);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Response word, captured on the address handshake.
  always_comb begin
    w_resp_data = 32'h0;
    w_resp_code = c_RESP_SLVERR;
    if (w_is_data) begin
      w_resp_code = c_RESP_OKAY;
      w_resp_data = w_empty ? 32'h8000_0000 : {24'h0, r_mem[r_rd_ptr]};
    end else if (w_is_stat) begin
      w_resp_code = c_RESP_OKAY;
      w_resp_data = {16'h0, w_count8, 6'h0, r_ovf, !w_empty};
    end
  end

  // FSM next state and channel outputs.
  always_comb begin
    w_next_state  = r_state;
    w_next_grant  = r_grant;
    bus.s_arready = '0;
    bus.s_rvalid  = '0;
    bus.s_rdata   = '0;
    bus.s_rresp   = '0;

    case (r_state)
      S_IDLE: begin
        if (|bus.s_arvalid) begin
          w_next_state = S_ADDR;
          w_next_grant = w_rr_pick;
        end
      end
      S_ADDR: begin
        if (w_arvalid_g) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rready_g) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase

    for (int i = 0; i < NUM_CPUS; i++) begin
      if (r_grant == c_GNT_W'(i)) begin
        bus.s_arready[i] = (r_state == S_ADDR);
        bus.s_rvalid[i]  = (r_state == S_RESP);
        if (r_state == S_RESP) begin
          bus.s_rdata[32*i +: 32] = r_rdata;
          bus.s_rresp[2*i +: 2]   = r_rresp;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_grant <= w_next_grant;
      if (w_hs) begin
        r_rdata <= w_resp_data;
        r_rresp <= w_resp_code;
      end
      if (r_state == S_RESP && w_rready_g) begin
        r_rr_ptr <= (r_grant == c_LAST_CPU) ? '0 : r_grant + 1'b1;
      end
      // Depth is a power of two, so the pointers wrap naturally.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Storage is not reset; reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_Rx_Byte;
    end
  end

`ifdef UART_RX_IRQ_EN
  logic r_rx_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_irq <= 1'b0;
    end else begin
      r_rx_irq <= (w_count_nxt != '0) || w_ovf_nxt;
    end
  end

  assign rx_irq = r_rx_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_responder
// Purpose  : Self-checking bench for uart_rx_responder: directed scenarios
//            plus randomized pushes/reads compared against a queue-based
//            model of the FIFO, overflow flag and round-robin order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_responder;

  localparam int          NUM_CPUS   = 2;
  localparam int          FIFO_DEPTH = 16;
  localparam logic [31:0] BASE_ADDR  = 32'h6000_0100;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx_dv   = 1'b0;
  logic [7:0] rx_byte = 8'h00;
`ifdef UART_RX_IRQ_EN
  logic       rx_irq;
`endif

  uart_rx_responder_if #(.NUM_CPUS(NUM_CPUS)) bus ();

  uart_rx_responder #(
    .NUM_CPUS   (NUM_CPUS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BASE_ADDR  (BASE_ADDR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_Rx_DV   (rx_dv),
    .i_Rx_Byte (rx_byte),
`ifdef UART_RX_IRQ_EN
    .rx_irq    (rx_irq),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;

  // Reference model
  logic [7:0] m_q[$];
  bit         m_ovf = 1'b0;
  int         m_rr  = 0;
  int         served[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (m_q.size() < FIFO_DEPTH) m_q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    if (addr == BASE_ADDR) begin
      r = 2'b00;
      if (m_q.size() > 0) d = {24'h0, m_q.pop_front()};
      else d = 32'h8000_0000;
    end else if (addr == BASE_ADDR + 32'd4) begin
      r = 2'b00;
      d = {16'h0, 8'(m_q.size()), 6'h0, m_ovf, (m_q.size() != 0)};
      m_ovf = 1'b0;
    end else begin
      r = 2'b10;
      d = 32'h0;
    end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE_ADDR;
      3:       return BASE_ADDR + 32'd4;
      4:       return BASE_ADDR + 32'd8 + 32'(4 * $urandom_range(0, 957));
      default: return 32'h6000_0FFF;
    endcase
  endfunction

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    model_push(b);
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    rx_dv          = 1'b0;
    bus.s_arvalid  = '0;
    bus.s_rready   = '0;
    m_q.delete();
    m_ovf = 1'b0;
    m_rr  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full read on a core. Optional byte push on the handshake cycle,
  // optional reset while the response is pending.
  task automatic do_read(input int core, input logic [31:0] addr, input int stall,
                         input bit push_hs, input logic [7:0] hs_byte, input bit abort_rsp,
                         output logic [31:0] got, output logic [1:0] got_resp);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    logic [31:0] held;
    bit          seen;
    got      = '0;
    got_resp = '0;
    seen     = 1'b0;
    @(negedge clk);
    bus.s_arvalid[core]         = 1'b1;
    bus.s_araddr[32*core +: 32] = addr;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      seen = bus.s_arready[core];
    end
    if (!seen) begin
      check_val("arready_timeout", 32'd0, 32'd1);
      bus.s_arvalid[core] = 1'b0;
      return;
    end
    check_val("arready_onehot", 32'(bus.s_arready), 32'd1 << core);
    if (push_hs) begin
      rx_dv   = 1'b1;
      rx_byte = hs_byte;
    end
    model_read(addr, exp_d, exp_r);
    if (push_hs) model_push(hs_byte);
    served.push_back(core);
    m_rr = (core + 1) % NUM_CPUS;
    @(posedge clk);
    #1;
    bus.s_arvalid[core] = 1'b0;
    rx_dv = 1'b0;
    @(negedge clk);
    check_val("rvalid_latency", 32'(bus.s_rvalid), 32'd1 << core);
    got      = bus.s_rdata[32*core +: 32];
    got_resp = bus.s_rresp[2*core +: 2];
    check_val("rdata", got, exp_d);
    check_val("rresp", 32'(got_resp), 32'(exp_r));
    held = got;
    if (abort_rsp) begin
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_async_rvalid", 32'(bus.s_rvalid), 32'd0);
      check_val("rst_async_rdata", bus.s_rdata[32*core +: 32], 32'd0);
      m_q.delete();
      m_ovf = 1'b0;
      m_rr  = 0;
      return;
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check_val("rvalid_hold", 32'(bus.s_rvalid[core]), 32'd1);
      check_val("rdata_hold", bus.s_rdata[32*core +: 32], held);
    end
    bus.s_rready[core] = 1'b1;
    @(posedge clk);
    #1;
    bus.s_rready[core] = 1'b0;
    @(negedge clk);
    check_val("rvalid_drop", 32'(bus.s_rvalid[core]), 32'd0);
  endtask

  // Both cores request in the same cycle; the model's pointer core goes first.
  task automatic dual_read(input logic [31:0] a0, input logic [31:0] a1,
                           output logic [31:0] d0, output logic [31:0] d1);
    int          exp_first;
    logic [31:0] t0, t1;
    logic [1:0]  r0, r1;
    int          s0, s1;
    s0 = $urandom_range(0, 3);
    s1 = $urandom_range(0, 3);
    served.delete();
    exp_first = m_rr;
    fork
      do_read(0, a0, s0, 1'b0, 8'h00, 1'b0, t0, r0);
      do_read(1, a1, s1, 1'b0, 8'h00, 1'b0, t1, r1);
    join
    d0 = t0;
    d1 = t1;
    check_val("rr_served_count", 32'(served.size()), 32'd2);
    if (served.size() == 2) begin
      check_val("rr_first", 32'(served[0]), 32'(exp_first));
      check_val("rr_second", 32'(served[1]), 32'(1 - exp_first));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [31:0] d, d0, d1;
    logic [1:0]  r;
    int          op;
    int          nb;

    bus.s_arvalid = '0;
    bus.s_araddr  = '0;
    bus.s_rready  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_arready", 32'(bus.s_arready), 32'd0);
    check_val("rst_rvalid", 32'(bus.s_rvalid), 32'd0);
    check_val("rst_rdata", bus.s_rdata[31:0], 32'd0);
    check_val("rst_rdata_hi", bus.s_rdata[63:32], 32'd0);
    check_val("rst_rresp", 32'(bus.s_rresp), 32'd0);
`ifdef UART_RX_IRQ_EN
    check_val("rst_irq", 32'(rx_irq), 32'd0);
`endif
    rst_n = 1'b1;

    // Simultaneous requests, round-robin from core 0
    push_byte(8'h10);
    push_byte(8'h20);
    dual_read(BASE_ADDR, BASE_ADDR, d0, d1);
    check_val("dual1_core0", d0, 32'h10);
    check_val("dual1_core1", d1, 32'h20);
    push_byte(8'h30);
    push_byte(8'h40);
    dual_read(BASE_ADDR, BASE_ADDR, d0, d1);
    check_val("dual2_core0", d0, 32'h30);
    check_val("dual2_core1", d1, 32'h40);

    // Basic data path
    push_byte(8'h41);
    push_byte(8'h42);
    do_read(0, BASE_ADDR, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("basic_first", d, 32'h41);
    do_read(0, BASE_ADDR, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("basic_second", d, 32'h42);
    do_read(0, BASE_ADDR + 32'd4, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("basic_status", d, 32'h0);

    // Empty read and decode error
    do_read(0, BASE_ADDR, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("empty_data", d, 32'h8000_0000);
    check_val("empty_resp", 32'(r), 32'd0);
    do_read(1, 32'h6000_0200, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("bad_data", d, 32'h0);
    check_val("bad_resp", 32'(r), 32'd2);
    do_read(1, BASE_ADDR + 32'd4, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("status_after_bad", d, 32'h0);

    // Overflow, sticky clear, push+pop while full
    apply_reset();
    for (int i = 0; i < 17; i++) push_byte(8'(i + 1));
    do_read(0, BASE_ADDR + 32'd4, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("ovf_status1", d, 32'h0000_1003);
    do_read(1, BASE_ADDR + 32'd4, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("ovf_status2", d, 32'h0000_1001);
    do_read(0, BASE_ADDR, 0, 1'b1, 8'hAA, 1'b0, d, r);
    check_val("full_pushpop_data", d, 32'h01);
    do_read(1, BASE_ADDR + 32'd4, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("full_pushpop_status", d, 32'h0000_1001);
    for (int i = 0; i < 16; i++) do_read(i % 2, BASE_ADDR, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("drain_last", d, 32'hAA);

    // Stalled response
    push_byte(8'h77);
    push_byte(8'h78);
    do_read(0, BASE_ADDR, 5, 1'b0, 8'h00, 1'b0, d, r);
    check_val("stall_data", d, 32'h77);
    do_read(1, BASE_ADDR + 32'd4, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("stall_one_pop", d, 32'h0000_0101);

    // Reset during the response phase
    push_byte(8'h55);
    push_byte(8'h66);
    do_read(1, BASE_ADDR, 0, 1'b0, 8'h00, 1'b1, d, r);
    @(negedge clk);
    bus.s_arvalid = '0;
    bus.s_rready  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(0, BASE_ADDR, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("post_abort_read", d, 32'h8000_0000);
    do_read(0, BASE_ADDR + 32'd4, 0, 1'b0, 8'h00, 1'b0, d, r);
    check_val("post_abort_status", d, 32'h0);

    // Randomized traffic
    for (int it = 0; it < 250; it++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        nb = $urandom_range(1, 8);
        for (int j = 0; j < nb; j++) push_byte(8'($urandom_range(0, 255)));
      end else if (op < 8) begin
        do_read($urandom_range(0, 1), pick_addr(), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 1'b0, d, r);
      end else begin
        dual_read(pick_addr(), pick_addr(), d0, d1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
